data_sram_responder: RTL

Data-side SRAM-like responder: the memory end of the data port driven by the MEM stage. It accepts read/write requests with a req/addr_ok handshake and holds up to OUTSTANDING requests in flight. Each request is answered in order with a one-cycle data_ok pulse after a configurable latency. It serves as the data RAM in the SoC simulation top, and is the stall source that exercises the MEM stage's wait logic.

---
 rtl/data_sram_pkg.sv | 52 +++++
 rtl/data_sram_responder_resp_queue.sv | 95 +++++++++
 rtl/data_sram_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/data_sram_pkg.sv
// data_sram_pkg
// Shared definitions for the data-side SRAM responder: LFSR seed and taps,
// the response-queue entry layout, access-size encodings, parameter bounds,
// and small helper functions (byte-lane merge, LFSR step).
package data_sram_pkg;

  // 16-bit Fibonacci LFSR used for the optional random stall generator.
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          LFSR_TAP_A = 16;
  localparam int          LFSR_TAP_B = 14;
  localparam int          LFSR_TAP_C = 13;
  localparam int          LFSR_TAP_D = 11;

  // Legal parameter ranges for the responder.
  localparam int LATENCY_MIN     = 1;
  localparam int LATENCY_MAX     = 7;
  localparam int OUTSTANDING_MIN = 1;
  localparam int OUTSTANDING_MAX = 4;

  // One in-flight response: returned data plus remaining countdown.
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
  } resp_entry_t;

  // Access-size encodings carried on data_sram_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Replace the bytes of old_word selected by wstrb with the matching wdata bytes.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

  // One step of the Fibonacci LFSR (taps 16,14,13,11), shifting towards the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1] ^ s[LFSR_TAP_C-1] ^ s[LFSR_TAP_D-1];
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// resp_queue
// Circular FIFO of in-flight responses. Each entry carries its response data
// and a countdown that loads LATENCY-1 on push and decrements every cycle
// while nonzero (independently of any stall). The head is ready once valid
// with a zero countdown.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears pointers,
//               count and valids; in-flight entries are discarded)
//   push        enqueue push_data this cycle (caller guarantees not full)
//   push_data   data to store for the new entry (0 for writes)
//   pop         retire the head this cycle (caller guarantees head_ready)
//   head_ready  head entry valid and its countdown expired
//   head_data   data of the head entry
//   count       number of occupied entries
module resp_queue
  import data_sram_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_ready,
  output logic [31:0] head_data,
  output logic [2:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      entry_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [2:0]       count_r;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Queue state: entries, valids, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 3'd0;
      valid_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // The push slot is never the head being popped: a full queue cannot push.
        if (push && (wr_ptr_r == PTR_W'(i))) begin
          entry_r[i].data <= push_data;
          entry_r[i].cnt  <= 3'(LATENCY - 1);
          valid_r[i]      <= 1'b1;
        end else begin
          if (entry_r[i].cnt != 3'd0) begin
            entry_r[i].cnt <= entry_r[i].cnt - 3'd1;
          end
          if (pop && (rd_ptr_r == PTR_W'(i))) begin
            valid_r[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head status and occupancy outputs.
  always_comb begin
    head_ready = valid_r[rd_ptr_r] && (entry_r[rd_ptr_r].cnt == 3'd0);
    head_data  = entry_r[rd_ptr_r].data;
    count      = count_r;
  end

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Memory end of the MEM-stage data port. Accepts read/write requests with a
// req/addr_ok handshake, keeps up to OUTSTANDING of them in flight, and
// answers each in order with a one-cycle data_ok pulse after LATENCY cycles.
// Reads sample the array at acceptance; writes apply byte enables at
// acceptance and answer with rdata 0. Memory contents are not reset.
// Optional feature macro: RANDOM_DELAY_EN -- an LFSR injects random
// acceptance (a_stall) and response (d_stall) stalls.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   data_sram_req       request valid
//   data_sram_wr        1 = write, 0 = read
//   data_sram_size      byte/half/word (no effect on the memory)
//   data_sram_wstrb     byte write enables (writes only)
//   data_sram_addr      byte address; word index = addr[ADDR_WIDTH+1:2]
//   data_sram_wdata     lane-replicated write data
//   data_sram_addr_ok   request accepted when req && addr_ok
//   data_sram_data_ok   head response valid (one-cycle pulse)
//   data_sram_rdata     read data with data_ok, else 0
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int LATENCY     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX) ||
      (OUTSTANDING < OUTSTANDING_MIN) || (OUTSTANDING > OUTSTANDING_MAX)) begin : g_bad_cfg
    $error("data_sram_responder: LATENCY or OUTSTANDING out of range");
  end

  logic [31:0]           mem_r [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic                  accept_s;
  logic [31:0]           push_data_s;
  logic                  head_ready_s;
  logic [31:0]           head_data_s;
  logic [2:0]            count_s;
  logic                  a_stall_s;
  logic                  d_stall_s;
  logic                  unused_s;

  // Size and the address bits outside the word index do not affect the memory.
  assign unused_s = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  assign word_idx_s = data_sram_addr[ADDR_WIDTH+1:2];
  assign accept_s   = data_sram_req && data_sram_addr_ok;

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr_r;

  // Free-running stall LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign a_stall_s = (lfsr_r[1:0] == 2'b11);
  assign d_stall_s = (lfsr_r[3:2] == 2'b11);
`else
  assign a_stall_s = 1'b0;
  assign d_stall_s = 1'b0;
`endif

  // Reads capture the array word at acceptance, so a later write cannot change them.
  always_comb begin
    if (data_sram_wr) begin
      push_data_s = 32'd0;
    end else begin
      push_data_s = mem_r[word_idx_s];
    end
  end

  // Byte-enabled array write at acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && data_sram_wr) begin
      mem_r[word_idx_s] <= byte_merge(mem_r[word_idx_s], data_sram_wdata, data_sram_wstrb);
    end
  end

  resp_queue #(
    .DEPTH   (OUTSTANDING),
    .LATENCY (LATENCY)
  ) u_resp_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_s),
    .push_data  (push_data_s),
    .pop        (data_sram_data_ok),
    .head_ready (head_ready_s),
    .head_data  (head_data_s),
    .count      (count_s)
  );

  // Handshake outputs. addr_ok looks only at registered occupancy, so a
  // same-cycle retirement frees a slot from the next cycle on.
  always_comb begin
    data_sram_addr_ok = !rst && (count_s < 3'(OUTSTANDING)) && !a_stall_s;
    data_sram_data_ok = head_ready_s && !d_stall_s;
    if (data_sram_data_ok) begin
      data_sram_rdata = head_data_s;
    end else begin
      data_sram_rdata = 32'd0;
    end
  end

endmodule
